// File: rtl/ydiv_pkg.sv
// Shared constants and state encoding for the sequential MIPS divider.
package ydiv_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } ydiv_state_e;

endpackage

// File: rtl/ydiv_step.sv
// One restoring shift-subtract step: shift the dividend MSB into the partial
// remainder and subtract the divisor with a (WIDTH+1)-bit add, carry-in 1.
module ydiv_step
  import ydiv_pkg::*;
#(
  parameter int WIDTH = ydiv_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, dvd_msb_i};
  assign trial   = shifted + {1'b1, ~dvs_i} + (WIDTH+1)'(1);

  // rem < divisor always holds, so the difference fits a signed WIDTH+1
  // value and its top bit is exactly the borrow.
  assign q_bit_o = ~trial[WIDTH];
  assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ydiv_seq.sv
// Sequential signed/unsigned divider (DIV/DIVU) with start/done handshake.
// Handshake: start is sampled only in IDLE; done pulses one cycle with q/r/dbz valid.
module ydiv_seq
  import ydiv_pkg::*;
#(
  parameter int WIDTH = ydiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output ydiv_state_e      dbg_state
);

  ydiv_state_e      state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_op_q, dbz_op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  // -2^31 negates to itself and is read as the unsigned 0x8000_0000.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  ydiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_op_d  = dbz_op_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (b == '0) begin
            // Divide by zero skips RUN; dvd carries the raw dividend to FIX.
            dvd_d    = a;
            dbz_op_d = 1'b1;
            state_d  = ST_FIX;
          end else begin
            dvd_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_signed & a[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            dbz_op_d  = 1'b0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_STEPS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dbz_op_q) begin
          q_d   = DBZ_QUOT;
          r_d   = dvd_q;
          dbz_d = 1'b1;
        end else begin
          q_d   = neg_quo_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          r_d   = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_op_q  <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_op_q  <= dbz_op_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  // The divide-by-zero pass through FIX is not a busy period.
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FIX && !dbz_op_q);
  assign done      = done_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ydiv_seq.sv
// Bench for ydiv_seq: arithmetic model of truncating division, expected-result
// queue consumed on every done, and per-cycle hold checks of q/r/dbz.
module tb_ydiv_seq;
  import ydiv_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [W-1:0] a, b;
  logic        busy, done, dbz;
  logic [W-1:0] q, r;
  ydiv_state_e dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_dbz_q[$];

  logic [W-1:0] cur_q, cur_r;
  logic         cur_dbz;
  logic         rst_seen = 1'b0;
  logic         mon_on   = 1'b0;

  ydiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Truncating division: quotient toward zero, remainder takes dividend sign.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] mq, output logic [W-1:0] mr, output logic md);
    logic signed [W-1:0] sa, sb;
    sa = ma;
    sb = mb;
    md = 1'b0;
    if (mb == 0) begin
      mq = 32'hFFFF_FFFF;
      mr = ma;
      md = 1'b1;
    end else if (ms) begin
      if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        mq = 32'h8000_0000;
        mr = 0;
      end else begin
        mq = sa / sb;
        mr = sa % sb;
      end
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(posedge clk) rst_seen = reset;

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_seen) begin
        cur_q   = '0;
        cur_r   = '0;
        cur_dbz = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          cur_q   = exp_q.pop_front();
          cur_r   = exp_r_q.pop_front();
          cur_dbz = exp_dbz_q.pop_front();
        end
      end
      check("q", q, cur_q);
      check("r", r, cur_r);
      check("dbz", W'(dbz), W'(cur_dbz));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a clock edge; the next edge is T0.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input int poke_at);
    logic [W-1:0] mq, mr;
    logic         md;
    int           n, busy_n, exp_lat, exp_busy;
    model(ta, tb_v, ts, mq, mr, md);
    exp_q.push_back(mq);
    exp_r_q.push_back(mr);
    exp_dbz_q.push_back(md);
    exp_lat  = (tb_v == 0) ? 1 : 33;
    exp_busy = (tb_v == 0) ? 0 : 33;
    a = ta;
    b = tb_v;
    is_signed = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    n = 0;
    busy_n = busy ? 1 : 0;
    while (!done && n < 100) begin
      if (n == poke_at) begin
        start = 1'b1;
        a = 32'd5;
        b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_n++;
    end
    start = 1'b0;
    check("latency", W'(n), W'(exp_lat));
    check("busy_cycles", W'(busy_n), W'(exp_busy));
  endtask

  task automatic abort_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic seen;
    a = ta;
    b = tb_v;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_state", W'(dbg_state), W'(ST_IDLE));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", W'(seen), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] mq, mr, ta, tbv;
    logic         md, ts;

    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    reset = 1'b0;

    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_q", q, '0);
    check("rst_r", r, '0);
    check("rst_dbz", W'(dbz), '0);

    // Pin the model with hand-computed values.
    model(32'd100, 32'd7, 1'b0, mq, mr, md);
    check("model_u_q", mq, 32'd14);
    check("model_u_r", mr, 32'd2);
    model(32'hFFFF_FF9C, 32'd7, 1'b1, mq, mr, md);
    check("model_sn_q", mq, 32'hFFFF_FFF2);
    check("model_sn_r", mr, 32'hFFFF_FFFE);
    model(32'd100, 32'hFFFF_FFF9, 1'b1, mq, mr, md);
    check("model_sd_q", mq, 32'hFFFF_FFF2);
    check("model_sd_r", mr, 32'd2);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, md);
    check("model_ovf_q", mq, 32'h8000_0000);
    check("model_ovf_r", mr, 32'd0);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mq, mr, md);
    check("model_ovfu_q", mq, 32'd0);
    check("model_ovfu_r", mr, 32'h8000_0000);
    model(32'h1234_5678, 32'd0, 1'b1, mq, mr, md);
    check("model_dbz_q", mq, 32'hFFFF_FFFF);
    check("model_dbz_r", mr, 32'h1234_5678);
    check("model_dbz_f", W'(md), 32'd1);

    // Directed operations (consecutive calls start while done is high).
    do_op(32'd100, 32'd7, 1'b0, -1);
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1);
    do_op(32'd100, 32'hFFFF_FFF9, 1'b1, -1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    do_op(32'h1234_5678, 32'd0, 1'b1, -1);
    do_op(32'd9, 32'd4, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    do_op(32'd1000, 32'd3, 1'b0, 5);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    do_op(32'd5, 32'hFFFF_FFFF, 1'b1, -1);
    abort_op(32'd77, 32'd5);
    do_op(32'd77, 32'd5, 1'b1, -1);

    // Random operands, both modes, occasional zero divisor.
    for (int i = 0; i < 1000; i++) begin
      ta  = $urandom;
      tbv = $urandom;
      ts  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tbv = W'($urandom_range(1, 20));
      if ($urandom_range(0, 19) == 0) tbv = '0;
      do_op(ta, tbv, ts, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_empty", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
